// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO draining into a UART transmitter; define UART_TX_FIFO_OVERFLOW_EN for a sticky overflow flag
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  input  logic          tx_busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic          push, pop;
  always_comb begin
    full      = level_q == LW'(DEPTH);
    empty     = level_q == '0;
    push      = wr_en && !full && !flush;
    pop       = !flush && state_q == S_IDLE && !empty && !tx_busy;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(pop);
    level_d   = flush ? '0 : level_q + LW'(push) - LW'(pop);
    tx_wr_d   = pop;
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    state_d   = flush ? S_IDLE :
                (state_q == S_IDLE)  ? (pop ? S_ISSUE : S_IDLE) :
                (state_q == S_ISSUE) ? S_HOLD :
                (state_q == S_HOLD)  ? (tx_busy ? S_WAIT : S_HOLD) :
                (tx_busy ? S_WAIT : S_IDLE);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
    end
  assign level   = level_q;
  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign ovf_d = flush ? 1'b0 : ovf_q | (wr_en & full);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-model bench for uart_tx_fifo with an emulated transmitter
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif
  logic       clk = 1'b0, resetn = 1'b1, flush = 1'b0, wr_en = 1'b0, tx_busy = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_wr;
  logic [4:0] level;
  logic [7:0] tx_data;
  int total = 0, passed = 0;
  logic [7:0] q [$];
  logic exp_ovf = 1'b0, prev_wr = 1'b0, pend = 1'b0, emu_en = 1'b0;
  logic [7:0] last_data = 8'h00;
  int busy_left = 0, busy_len = 20;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    exp_ovf = 1'b0; prev_wr = 1'b0; pend = 1'b0; busy_left = 0; tx_busy = 1'b0; last_data = 8'h00;
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic f);
    int pre;
    logic acc;
    pre = q.size();
    wr_en = w; wr_data = d; flush = f;
    acc = w && !f && pre < DEPTH;
    if (w && !f && pre == DEPTH) exp_ovf = OVF_EN;
    @(posedge clk); #1;
    wr_en = 1'b0; flush = 1'b0;
    if (f) begin q.delete(); exp_ovf = 1'b0; end
    if (acc) q.push_back(d);
    if (tx_wr === 1'b1) begin
      chk("tx_wr_one_cycle", {31'd0, prev_wr}, 0);
      if (q.size() == 0) chk("spurious_strobe", 1, 0);
      else begin last_data = q.pop_front(); chk("tx_data", {24'd0, tx_data}, {24'd0, last_data}); end
    end else chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_data});
    prev_wr = tx_wr;
    chk("level", {27'd0, level}, q.size());
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    if (emu_en) begin
      if (busy_left > 0) begin busy_left--; if (busy_left == 0) tx_busy = 1'b0; end
      if (pend) begin tx_busy = 1'b1; busy_left = busy_len; pend = 1'b0; end
      if (tx_wr === 1'b1) pend = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || tx_busy || pend || busy_left != 0) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_tx_wr", {31'd0, tx_wr}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    model_reset();

    emu_en = 1'b1; busy_len = 20;
    step(1'b1, 8'hA5, 1'b0);
    chk("single_no_early_strobe", {31'd0, tx_wr}, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_strobe", {31'd0, tx_wr}, 1);
    chk("single_data", {24'd0, tx_data}, 32'hA5);
    chk("single_level", {27'd0, level}, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_strobe_ends", {31'd0, tx_wr}, 0);
    drain();

    emu_en = 1'b0; tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    chk("busy_level5", {27'd0, level}, 5);
    chk("busy_no_strobe", {31'd0, tx_wr}, 0);
    emu_en = 1'b1; busy_left = 1;
    drain();
    chk("order_empty", {31'd0, empty}, 1);

    emu_en = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("full_flag", {31'd0, full}, 1);
    chk("full_level", {27'd0, level}, 16);
    chk("full_overflow", {31'd0, overflow}, {31'd0, OVF_EN});
    emu_en = 1'b1; busy_left = 1;
    drain();
    busy_len = 2;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    drain();

    emu_en = 1'b0; tx_busy = 1'b1;
    step(1'b1, 8'h33, 1'b0);
    tx_busy = 1'b0; emu_en = 1'b1; busy_len = 20;
    step(1'b1, 8'h77, 1'b0);
    chk("simul_strobe", {31'd0, tx_wr}, 1);
    chk("simul_level", {27'd0, level}, 1);
    drain();

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_flush_level", {27'd0, level}, 4);
    step(1'b1, 8'h99, 1'b1);
    chk("flush_level", {27'd0, level}, 0);
    chk("flush_overflow", {31'd0, overflow}, 0);
    chk("flush_tx_wr", {31'd0, tx_wr}, 0);
    repeat (25) step(1'b0, 8'h00, 1'b0);
    chk("flush_busy_done", {31'd0, tx_busy}, 0);
    step(1'b1, 8'h42, 1'b0);
    drain();

    emu_en = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
    chk("hold_level3", {27'd0, level}, 3);
    resetn = 1'b0;
    #1;
    chk("arst_level", {27'd0, level}, 0);
    chk("arst_empty", {31'd0, empty}, 1);
    chk("arst_full", {31'd0, full}, 0);
    chk("arst_tx_wr", {31'd0, tx_wr}, 0);
    chk("arst_tx_data", {24'd0, tx_data}, 0);
    chk("arst_overflow", {31'd0, overflow}, 0);
    #1 resetn = 1'b1;
    model_reset();
    repeat (3) step(1'b0, 8'h00, 1'b0);

    emu_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      busy_len = $urandom_range(1, 6);
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 199) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
